// File: rtl/gtxe2_chnl_tx_oobseq.sv
// gtxe2_chnl_tx_oobseq: SATA/SAS OOB burst/gap sequencer emitting ALIGNp bursts separated by electrical idle
// Optional feature macro: OOB_COMSAS_EN adds the TXCOMSAS request (lowest priority, SAS_GAP_LEN gaps).
module gtxe2_chnl_tx_oobseq #(
    parameter int WIDTH        = 20,
    parameter int BURST_CNT    = 6,
    parameter int BURST_LEN    = 16,
    parameter int INIT_GAP_LEN = 48,
    parameter int WAKE_GAP_LEN = 16,
    parameter int SAS_GAP_LEN  = 144
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             TXCOMINIT,
    input  logic             TXCOMWAKE,
`ifdef OOB_COMSAS_EN
    input  logic             TXCOMSAS,
`endif
    input  logic             disparity,
    output logic [WIDTH-1:0] outdata,
    output logic             outval,
    output logic             idle,
    output logic             busy,
    output logic             TXCOMFINISH,
    output logic             out_disp
);
    localparam int NS   = WIDTH / 10;
    localparam int M1   = BURST_LEN > INIT_GAP_LEN ? BURST_LEN : INIT_GAP_LEN;
    localparam int M2   = M1 > WAKE_GAP_LEN ? M1 : WAKE_GAP_LEN;
    localparam int MAXL = M2 > SAS_GAP_LEN ? M2 : SAS_GAP_LEN;
    localparam int CW   = $clog2(MAXL + 1);
    localparam int BW   = $clog2(BURST_CNT + 1);

    localparam logic [9:0] K28_N = 10'b0011111010;
    localparam logic [9:0] K28_P = 10'b1100000101;
    localparam logic [9:0] D10   = 10'b0101010101;
    localparam logic [9:0] D27_N = 10'b1101100011;
    localparam logic [9:0] D27_P = 10'b0010011100;

    typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    gap_len_q, gap_len_d;
    logic [BW-1:0]    burst_no_q, burst_no_d;
    logic [1:0]       sym_q, sym_d;
    logic [WIDTH-1:0] outdata_q, outdata_d;
    logic             outval_q, outval_d;
    logic             idle_q, idle_d;
    logic             busy_q, busy_d;
    logic             finish_q, finish_d;
    logic             out_disp_q, out_disp_d;

    logic             req;
    logic [CW-1:0]    req_gap;
    logic [WIDTH-1:0] sym_data;
    logic             sym_rd;
    logic [1:0]       s;
    logic [9:0]       code;

`ifdef OOB_COMSAS_EN
    assign req     = TXCOMINIT | TXCOMWAKE | TXCOMSAS;
    assign req_gap = TXCOMINIT ? CW'(INIT_GAP_LEN) : TXCOMWAKE ? CW'(WAKE_GAP_LEN) : CW'(SAS_GAP_LEN);
`else
    assign req     = TXCOMINIT | TXCOMWAKE;
    assign req_gap = TXCOMINIT ? CW'(INIT_GAP_LEN) : CW'(WAKE_GAP_LEN);
`endif

    // Sequence control: phase counter, burst counter and the gap length chosen at request time
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_len_d  = gap_len_q;
        burst_no_d = burst_no_q;
        case (state_q)
            IDLE: if (req) begin
                state_d    = BURST;
                cnt_d      = '0;
                gap_len_d  = req_gap;
                burst_no_d = '0;
            end
            BURST: begin
                state_d = (cnt_q == CW'(BURST_LEN - 1)) ? GAP : BURST;
                cnt_d   = (cnt_q == CW'(BURST_LEN - 1)) ? '0 : cnt_q + CW'(1);
            end
            GAP: if (cnt_q == gap_len_q - CW'(1)) begin
                cnt_d      = '0;
                burst_no_d = burst_no_q + BW'(1);
                state_d    = (burst_no_q == BW'(BURST_CNT - 1)) ? DONE : BURST;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALIGNp symbols for this cycle; disparity restarts from the input on the first burst cycle
    always_comb begin
        sym_data = '0;
        s        = '0;
        code     = '0;
        sym_rd   = (cnt_q == '0) ? disparity : out_disp_q;
        for (int i = 0; i < NS; i++) begin
            s      = sym_q + 2'(i);
            code   = (s == 2'd0) ? (sym_rd ? K28_P : K28_N) : (s == 2'd3) ? (sym_rd ? D27_P : D27_N) : D10;
            sym_data[10*i +: 10] = code;
            sym_rd = sym_rd ^ (s == 2'd0 || s == 2'd3);
        end
    end

    // Registered outputs derived from the current phase
    always_comb begin
        outval_d   = state_q == BURST;
        idle_d     = state_q == GAP;
        busy_d     = state_q != IDLE;
        finish_d   = state_q == DONE;
        outdata_d  = (state_q == BURST) ? sym_data : '0;
        out_disp_d = (state_q == BURST) ? sym_rd : out_disp_q;
        sym_d      = (state_q == BURST) ? sym_q + 2'(NS) : 2'd0;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gap_len_q  <= '0;
            burst_no_q <= '0;
            sym_q      <= '0;
            outdata_q  <= '0;
            outval_q   <= 1'b0;
            idle_q     <= 1'b0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
            out_disp_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_len_q  <= gap_len_d;
            burst_no_q <= burst_no_d;
            sym_q      <= sym_d;
            outdata_q  <= outdata_d;
            outval_q   <= outval_d;
            idle_q     <= idle_d;
            busy_q     <= busy_d;
            finish_q   <= finish_d;
            out_disp_q <= out_disp_d;
        end
    end

    assign outdata     = outdata_q;
    assign outval      = outval_q;
    assign idle        = idle_q;
    assign busy        = busy_q;
    assign TXCOMFINISH = finish_q;
    assign out_disp    = out_disp_q;
endmodule

// File: tb/tb_gtxe2_chnl_tx_oobseq.sv
// tb_gtxe2_chnl_tx_oobseq: randomized self-checking bench for the OOB sequencer at WIDTH 20 and 40
module tb_gtxe2_chnl_tx_oobseq;
    localparam int BC = 6;
    localparam int BL = 4;
    localparam int IG = 12;
    localparam int WG = 4;

    logic        clk = 0;
    logic        reset = 1;
    logic        TXCOMINIT = 0;
    logic        TXCOMWAKE = 0;
    logic        disparity = 0;
    logic [19:0] outdata;
    logic        outval, idle, busy, fin, odisp;
    logic [39:0] outdata40;
    logic        outval40, idle40, busy40, fin40, odisp40;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    gtxe2_chnl_tx_oobseq #(.WIDTH(20), .BURST_CNT(BC), .BURST_LEN(BL), .INIT_GAP_LEN(IG), .WAKE_GAP_LEN(WG)) dut (
        .clk(clk), .reset(reset), .TXCOMINIT(TXCOMINIT), .TXCOMWAKE(TXCOMWAKE),
`ifdef OOB_COMSAS_EN
        .TXCOMSAS(1'b0),
`endif
        .disparity(disparity), .outdata(outdata), .outval(outval), .idle(idle), .busy(busy),
        .TXCOMFINISH(fin), .out_disp(odisp));

    gtxe2_chnl_tx_oobseq #(.WIDTH(40), .BURST_CNT(BC), .BURST_LEN(BL), .INIT_GAP_LEN(IG), .WAKE_GAP_LEN(WG)) dut40 (
        .clk(clk), .reset(reset), .TXCOMINIT(TXCOMINIT), .TXCOMWAKE(TXCOMWAKE),
`ifdef OOB_COMSAS_EN
        .TXCOMSAS(1'b0),
`endif
        .disparity(disparity), .outdata(outdata40), .outval(outval40), .idle(idle40), .busy(busy40),
        .TXCOMFINISH(fin40), .out_disp(odisp40));

    // Symbols of burst cycle o: walk the ALIGNp stream from burst start, flipping RD on K28.5/D27.3
    function automatic logic [79:0] exp_sym(input int ns, input int o, input bit d0, output bit dend);
        logic [79:0] r;
        bit          rd;
        int          k;
        logic [9:0]  c;
        r  = '0;
        rd = d0;
        for (int idx = 0; idx < (o + 1) * ns; idx++) begin
            k = idx % 4;
            c = (k == 0) ? (rd ? 10'b1100000101 : 10'b0011111010) :
                (k == 3) ? (rd ? 10'b0010011100 : 10'b1101100011) : 10'b0101010101;
            if (idx >= o * ns) r[10*(idx - o*ns) +: 10] = c;
            if (k == 0 || k == 3) rd = !rd;
        end
        dend = rd;
        return r;
    endfunction

    task automatic check_zero(input string tag);
        n_chk++;
        if ({outdata, outval, idle, busy, fin, odisp} !== 25'd0) begin
            n_fail++;
            $display("FAIL %s w20 outputs got %h required 0", tag, {outdata, outval, idle, busy, fin, odisp});
        end
        n_chk++;
        if ({outdata40, outval40, idle40, busy40, fin40, odisp40} !== 45'd0) begin
            n_fail++;
            $display("FAIL %s w40 outputs got %h required 0", tag, {outdata40, outval40, idle40, busy40, fin40, odisp40});
        end
    endtask

    // One request at the next edge (edge 0); checks every edge up to one past the finish pulse
    task automatic run_seq(input bit ci, input bit cw, input int hold, input int noise_e,
                           input int dmode, input int stop_e);
        int          g, L, total, p, o, b, bb;
        bit          d0[BC];
        bit          ev, ei, dd20, dd40;
        logic [79:0] x20, x40;
        logic [19:0] e20;
        logic [39:0] e40;
        g     = ci ? IG : WG;
        L     = BL + g;
        total = 1 + BC * L;
        for (int i = 0; i < BC; i++) d0[i] = (dmode == 2) ? 1'($urandom % 2) : 1'(dmode);
        disparity = d0[0];
        TXCOMINIT = ci;
        TXCOMWAKE = cw;
        @(posedge clk);
        #1;
        for (int e = 1; e <= total + 1; e++) begin
            @(posedge clk);
            #1;
            p   = e - 1;
            o   = p % L;
            b   = p / L;
            bb  = (b < BC) ? b : 0;
            ev  = (p < BC * L) && (o < BL);
            ei  = (p < BC * L) && (o >= BL);
            x20 = exp_sym(2, ev ? o : 0, d0[bb], dd20);
            x40 = exp_sym(4, ev ? o : 0, d0[bb], dd40);
            e20 = ev ? x20[19:0] : 20'd0;
            e40 = ev ? x40[39:0] : 40'd0;
            n_chk++;
            if (outval !== ev) begin n_fail++; $display("FAIL outval e=%0d got %b required %b", e, outval, ev); end
            n_chk++;
            if (idle !== ei) begin n_fail++; $display("FAIL idle e=%0d got %b required %b", e, idle, ei); end
            n_chk++;
            if (busy !== (e <= total)) begin n_fail++; $display("FAIL busy e=%0d got %b required %b", e, busy, e <= total); end
            n_chk++;
            if (fin !== (e == total)) begin n_fail++; $display("FAIL finish e=%0d got %b required %b", e, fin, e == total); end
            n_chk++;
            if (outdata !== e20) begin n_fail++; $display("FAIL outdata e=%0d got %b required %b", e, outdata, e20); end
            n_chk++;
            if (outval40 !== ev || fin40 !== (e == total)) begin
                n_fail++; $display("FAIL w40 ctl e=%0d got val %b fin %b required %b %b", e, outval40, fin40, ev, e == total);
            end
            n_chk++;
            if (outdata40 !== e40) begin n_fail++; $display("FAIL outdata40 e=%0d got %b required %b", e, outdata40, e40); end
            if (ev) begin
                n_chk++;
                if (odisp !== dd20) begin n_fail++; $display("FAIL out_disp e=%0d got %b required %b", e, odisp, dd20); end
                n_chk++;
                if (odisp40 !== dd40) begin n_fail++; $display("FAIL out_disp40 e=%0d got %b required %b", e, odisp40, dd40); end
                if (dmode == 0 && o == 0) begin
                    n_chk++;
                    if (outdata !== 20'b0101010101_0011111010) begin
                        n_fail++; $display("FAIL first_align e=%0d got %b required 0101010101_0011111010", e, outdata);
                    end
                end
                if (dmode == 1) begin
                    n_chk++;
                    if (outdata40 !== 40'b1101100011_0101010101_0101010101_1100000101 || odisp40 !== 1'b1) begin
                        n_fail++; $display("FAIL rdplus_w40 e=%0d got %b disp %b", e, outdata40, odisp40);
                    end
                end
            end
            if (e == stop_e) return;
            TXCOMINIT = (e == noise_e) ? 1'($urandom % 2) : ((e < hold) ? ci : 1'b0);
            TXCOMWAKE = (e == noise_e) ? 1'b1 : ((e < hold) ? cw : 1'b0);
            if (ei && o == BL && b + 1 < BC) disparity = d0[b + 1];
        end
        TXCOMINIT = 0;
        TXCOMWAKE = 0;
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        check_zero("reset");
        reset = 0;
        @(posedge clk);
        #1;
        check_zero("post_reset_idle");
    endtask

    task automatic test_cominit;
        run_seq(1, 0, 1, 0, 2, 0);
    endtask

    task automatic test_comwake;
        run_seq(0, 1, 1, 0, 0, 0);
        run_seq(0, 1, 3, 0, 1, 0);
    endtask

    task automatic test_priority;
        run_seq(1, 1, 1, 19, 2, 0);
    endtask

    task automatic test_reset_mid;
        run_seq(1, 0, 1, 0, 2, 1 + 2 * (BL + IG) + BL + 3);
        TXCOMINIT = 0;
        TXCOMWAKE = 0;
        #2;
        reset = 1;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_zero("after_abort");
        end
        run_seq(1, 0, 1, 0, 2, 0);
    endtask

    task automatic test_random;
        bit ci, cw;
        int tot;
        for (int n = 0; n < 5; n++) begin
            ci  = 1'($urandom % 2);
            cw  = ci ? 1'($urandom % 2) : 1'b1;
            tot = 1 + BC * (BL + (ci ? IG : WG));
            run_seq(ci, cw, $urandom_range(1, 20), $urandom_range(2, tot - 2), 2, 0);
        end
    endtask

    task automatic test_back_to_back;
        run_seq(0, 1, 1, 0, 2, 0);
        run_seq(1, 0, 2, 0, 2, 0);
    endtask

    initial begin
        test_reset();
        test_cominit();
        test_comwake();
        test_priority();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
